seg7_hex_counter_driver: RTL and testbench

//   Display stage that drives the tile's dedicated outputs (uo_out, seven-segment display) from the input switches (ui_in).

---
 rtl/seg7_hex_counter_driver_if.sv | 11 +
 rtl/seg7_hex_counter_driver.sv | 130 +++++++++++++
 tb/tb_seg7_hex_counter_driver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_hex_counter_driver_if.sv
// Enable, switch inputs and display outputs of the seven-segment counter stage.
interface seg7_hex_counter_driver_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] seg_out;
  logic [3:0] count_out;
  logic       tick_out;

  modport master (output ena, ui_in, input seg_out, count_out, tick_out);
  modport slave  (input ena, ui_in, output seg_out, count_out, tick_out);
endinterface

// File: rtl/seg7_hex_counter_driver.sv
// Heartbeat prescaler, debounced step button and loadable up/down hex counter
// driving an active-high seven-segment display with a blinking decimal point.
module seg7_hex_counter_driver #(
  parameter int PRESCALE_DIV    = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input logic                       clk,
  input logic                       reset,
  seg7_hex_counter_driver_if.slave  bus
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} db_state_t;

  logic [7:0]    sync1, sync2;
  logic          load_prev;
  logic [PW-1:0] presc;
  logic          tick;
  logic          dp;
  db_state_t     db_state, db_state_nx;
  logic [DW-1:0] db_cnt, db_cnt_nx;
  logic          step_pulse, load_pulse;
  logic [3:0]    count, count_nx;
  logic [6:0]    seg_enc;
  logic [7:0]    seg;

  assign tick       = (presc == PRESC_LAST);
  assign load_pulse = sync2[3] & ~load_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      load_prev <= 1'b0;
      presc     <= '0;
      dp        <= 1'b0;
    end else if (bus.ena) begin
      sync1     <= bus.ui_in;
      sync2     <= sync1;
      load_prev <= sync2[3];
      presc     <= tick ? '0 : presc + 1'b1;
      if (tick) dp <= ~dp;
    end
  end

  // step_pulse is combinational on the RISE_WAIT->HIGH transition so the
  // counter moves on the same edge the FSM settles into HIGH.
  always_comb begin
    db_state_nx = db_state;
    db_cnt_nx   = db_cnt;
    step_pulse  = 1'b0;
    case (db_state)
      LOW: if (sync2[0]) begin
        db_state_nx = RISE_WAIT;
        db_cnt_nx   = '0;
      end
      RISE_WAIT: begin
        if (!sync2[0]) db_state_nx = LOW;
        else if (db_cnt == DB_LAST) begin
          db_state_nx = HIGH;
          step_pulse  = 1'b1;
        end else db_cnt_nx = db_cnt + 1'b1;
      end
      HIGH: if (!sync2[0]) begin
        db_state_nx = FALL_WAIT;
        db_cnt_nx   = '0;
      end
      FALL_WAIT: begin
        if (sync2[0]) db_state_nx = HIGH;
        else if (db_cnt == DB_LAST) db_state_nx = LOW;
        else db_cnt_nx = db_cnt + 1'b1;
      end
      default: db_state_nx = LOW;
    endcase
  end

  // Load beats step beats run-tick; a coincident tick is simply dropped.
  always_comb begin
    count_nx = count;
    if (load_pulse) count_nx = sync2[7:4];
    else if (step_pulse || (tick && sync2[1]))
      count_nx = sync2[2] ? count + 4'd1 : count - 4'd1;
  end

  always_comb begin
    seg_enc = 7'h3F;
    case (count)
      4'h0: seg_enc = 7'h3F;
      4'h1: seg_enc = 7'h06;
      4'h2: seg_enc = 7'h5B;
      4'h3: seg_enc = 7'h4F;
      4'h4: seg_enc = 7'h66;
      4'h5: seg_enc = 7'h6D;
      4'h6: seg_enc = 7'h7D;
      4'h7: seg_enc = 7'h07;
      4'h8: seg_enc = 7'h7F;
      4'h9: seg_enc = 7'h6F;
      4'hA: seg_enc = 7'h77;
      4'hB: seg_enc = 7'h7C;
      4'hC: seg_enc = 7'h39;
      4'hD: seg_enc = 7'h5E;
      4'hE: seg_enc = 7'h79;
      4'hF: seg_enc = 7'h71;
      default: seg_enc = 7'h3F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state <= LOW;
      db_cnt   <= '0;
      count    <= '0;
      seg      <= 8'h3F;
    end else if (bus.ena) begin
      db_state <= db_state_nx;
      db_cnt   <= db_cnt_nx;
      count    <= count_nx;
      seg      <= {dp, seg_enc};
    end
  end

  assign bus.seg_out   = seg;
  assign bus.count_out = count;
  assign bus.tick_out  = tick;

endmodule

// File: tb/tb_seg7_hex_counter_driver.sv
// Directed bench for seg7_hex_counter_driver with a small prescaler and debounce.
module tb_seg7_hex_counter_driver;
  localparam int PDIV = 4;
  localparam int DBC  = 3;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  seg7_hex_counter_driver_if bus();

  seg7_hex_counter_driver #(
    .PRESCALE_DIV    (PDIV),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, returning on the following falling edge.
  task automatic edge_n(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (bus.tick_out !== 1'b1 && n < 20) begin
      edge_n(1);
      n++;
    end
    check("tick_wait", 32'(bus.tick_out), 32'd1);
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.ui_in[7:4] = v;
    bus.ui_in[3]   = 1'b1;
    edge_n(3);
    bus.ui_in[3]   = 1'b0;
    edge_n(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_cnt[3];
    logic [6:0] exp_seg[3];

    vecs[0]  = '{4'h0, 7'h3F}; vecs[1]  = '{4'h1, 7'h06};
    vecs[2]  = '{4'h2, 7'h5B}; vecs[3]  = '{4'h3, 7'h4F};
    vecs[4]  = '{4'h4, 7'h66}; vecs[5]  = '{4'h5, 7'h6D};
    vecs[6]  = '{4'h6, 7'h7D}; vecs[7]  = '{4'h7, 7'h07};
    vecs[8]  = '{4'h8, 7'h7F}; vecs[9]  = '{4'h9, 7'h6F};
    vecs[10] = '{4'hA, 7'h77}; vecs[11] = '{4'hB, 7'h7C};
    vecs[12] = '{4'hC, 7'h39}; vecs[13] = '{4'hD, 7'h5E};
    vecs[14] = '{4'hE, 7'h79}; vecs[15] = '{4'hF, 7'h71};
    exp_cnt[0] = 4'hF; exp_cnt[1] = 4'h0; exp_cnt[2] = 4'h1;
    exp_seg[0] = 7'h71; exp_seg[1] = 7'h3F; exp_seg[2] = 7'h06;

    reset     = 1'b1;
    bus.ena   = 1'b1;
    bus.ui_in = '0;
    @(negedge clk);
    edge_n(2);
    check("rst_count", 32'(bus.count_out), 32'h0);
    check("rst_seg",   32'(bus.seg_out),   32'h3F);
    check("rst_tick",  32'(bus.tick_out),  32'h0);
    reset = 1'b0;

    // Heartbeat cadence with run=0
    for (int k = 1; k <= 20; k++) begin
      edge_n(1);
      check("t1_tick",  32'(bus.tick_out),  32'((k % 4) == 3));
      check("t1_count", 32'(bus.count_out), 32'h0);
      check("t1_seg",   32'(bus.seg_out),   ((((k - 1) / 4) % 2) == 1) ? 32'hBF : 32'h3F);
    end

    // Short glitch rejected, stable press counts once
    bus.ui_in[2] = 1'b1;
    bus.ui_in[0] = 1'b1;
    edge_n(2);
    bus.ui_in[0] = 1'b0;
    edge_n(6);
    check("t2_glitch", 32'(bus.count_out), 32'h0);
    bus.ui_in[0] = 1'b1;
    edge_n(5);
    check("t2_edge5", 32'(bus.count_out), 32'h0);
    edge_n(1);
    check("t2_edge6", 32'(bus.count_out), 32'h1);
    check("t2_seg_lag", 32'(bus.seg_out[6:0]), 32'h3F);
    edge_n(1);
    check("t2_seg", 32'(bus.seg_out[6:0]), 32'h06);
    edge_n(3);
    check("t2_held", 32'(bus.count_out), 32'h1);
    bus.ui_in[0] = 1'b0;
    edge_n(8);
    check("t2_release", 32'(bus.count_out), 32'h1);

    // Load E then run up across the wrap
    bus.ui_in[7:4] = 4'hE;
    bus.ui_in[3]   = 1'b1;
    edge_n(2);
    check("t3_load_e2", 32'(bus.count_out), 32'h1);
    edge_n(1);
    check("t3_load_e3", 32'(bus.count_out), 32'hE);
    edge_n(1);
    check("t3_load_seg", 32'(bus.seg_out[6:0]), 32'h79);
    bus.ui_in[3] = 1'b0;
    wait_tick();
    edge_n(1);
    bus.ui_in[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      edge_n(1);
      check("t3_run_count", 32'(bus.count_out), 32'(exp_cnt[i]));
      if (i == 2) bus.ui_in[1] = 1'b0;
      edge_n(1);
      check("t3_run_seg", 32'(bus.seg_out[6:0]), 32'(exp_seg[i]));
    end

    // Encoder table through the load path
    for (int i = 0; i < 16; i++) begin
      do_load(vecs[i].val);
      check("tbl_count", 32'(bus.count_out),    32'(vecs[i].val));
      check("tbl_seg",   32'(bus.seg_out[6:0]), 32'(vecs[i].seg));
    end

    // Down step from 0 wraps to F
    bus.ui_in[2] = 1'b0;
    do_load(4'h0);
    check("t4_zero", 32'(bus.count_out), 32'h0);
    bus.ui_in[0] = 1'b1;
    edge_n(10);
    bus.ui_in[0] = 1'b0;
    edge_n(8);
    check("t4_count", 32'(bus.count_out),    32'hF);
    check("t4_seg",   32'(bus.seg_out[6:0]), 32'h71);

    // Load and step pulses coincide: load wins
    bus.ui_in[2]   = 1'b1;
    bus.ui_in[7:4] = 4'h5;
    bus.ui_in[0]   = 1'b1;
    edge_n(3);
    bus.ui_in[3] = 1'b1;
    edge_n(2);
    check("t5_before", 32'(bus.count_out), 32'hF);
    edge_n(1);
    check("t5_load", 32'(bus.count_out), 32'h5);
    edge_n(4);
    bus.ui_in[0] = 1'b0;
    bus.ui_in[3] = 1'b0;
    edge_n(8);
    check("t5_count", 32'(bus.count_out),    32'h5);
    check("t5_seg",   32'(bus.seg_out[6:0]), 32'h6D);

    // Reset mid-debounce, then full debounce from LOW with button still held
    do_load(4'h7);
    check("t6_loaded", 32'(bus.count_out), 32'h7);
    bus.ui_in[0] = 1'b1;
    edge_n(4);
    check("t6_pre_reset", 32'(bus.count_out), 32'h7);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_count", 32'(bus.count_out), 32'h0);
    check("t6_rst_seg",   32'(bus.seg_out),   32'h3F);
    check("t6_rst_tick",  32'(bus.tick_out),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    edge_n(5);
    check("t6_edge5", 32'(bus.count_out), 32'h0);
    edge_n(1);
    check("t6_edge6", 32'(bus.count_out), 32'h1);
    edge_n(9);
    check("t6_one_pulse", 32'(bus.count_out), 32'h1);
    check("t6_tick",      32'(bus.tick_out),  32'h1);
    check("t6_seg",       32'(bus.seg_out),   32'h86);

    // Enable low freezes everything; prescaler resumes where it stopped
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_n(1);
      check("ena_tick",  32'(bus.tick_out),  32'h1);
      check("ena_count", 32'(bus.count_out), 32'h1);
      check("ena_seg",   32'(bus.seg_out),   32'h86);
    end
    bus.ena = 1'b1;
    edge_n(1);
    check("resume1_tick", 32'(bus.tick_out), 32'h0);
    check("resume1_seg",  32'(bus.seg_out),  32'h86);
    edge_n(1);
    check("resume2_tick", 32'(bus.tick_out), 32'h0);
    check("resume2_seg",  32'(bus.seg_out),  32'h06);
    edge_n(1);
    check("resume3_tick", 32'(bus.tick_out), 32'h0);
    edge_n(1);
    check("resume4_tick", 32'(bus.tick_out), 32'h1);
    check("resume_count", 32'(bus.count_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
